// File: rtl/uart_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mon_pkg
// Brief    : Shared state encoding and bit-timing helper for the UART monitor.
// Revision : 1.0
// ============================================================================
package uart_mon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_mon_state_e;

    // Rounded to the nearest whole clock count per bit.
    function automatic int clks_per_bit(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_mon_fifo
// Brief    : Synchronous first-word-fall-through FIFO; pushes to a full FIFO
//            are dropped unless a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module uart_mon_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int              c_AW   = $clog2(Depth);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(Depth);
    localparam logic [c_AW-1:0] c_INC  = c_AW'(1);

    logic [Width-1:0] r_mem [Depth];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == c_FULL);
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_INC;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_INC;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_monitor
// Brief    : Serial receiver on the system UART TX line; buffers bytes in a
//            FWFT FIFO. Define UART_MON_PARITY_EN for even-parity frames.
// Revision : 1.0
// ============================================================================
module uart_tx_monitor
    import uart_mon_pkg::*;
#(
    parameter int SysClkFreq = 30_000_000,
    parameter int BaudRate   = 921_600,
    parameter int FifoDepth  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
`ifdef UART_MON_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);
    localparam int              c_CLKS      = clks_per_bit(SysClkFreq, BaudRate);
    localparam int              c_HALF      = c_CLKS / 2;
    localparam int              c_CW        = $clog2(c_CLKS);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_CLKS - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF - 1);

    logic            r_sync1;
    logic            r_rx_s;
    logic [1:0]      r_sync_vld;
    logic            r_rx_prev;
    uart_mon_state_e r_state;
    logic [c_CW-1:0] r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_frame_err;
    logic            r_overflow;
`ifdef UART_MON_PARITY_EN
    logic            r_par_bad;
    logic            r_parity_err;
`endif

    logic       w_fall;
    logic       w_bit_tick;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_bit_tick = (r_baud_cnt == c_BIT_LAST);
`ifdef UART_MON_PARITY_EN
    assign w_push     = (r_state == STOP) & w_bit_tick & r_rx_s & ~r_par_bad;
    assign parity_err_o = r_parity_err;
`else
    assign w_push     = (r_state == STOP) & w_bit_tick & r_rx_s;
`endif
    assign w_pop        = ~w_empty & byte_ready_i;
    assign byte_valid_o = ~w_empty;
    assign byte_o       = w_empty ? 8'h00 : w_head;
    assign frame_err_o  = r_frame_err;
    assign overflow_o   = r_overflow;
    assign busy_o       = (r_state != IDLE);

    // The synchroniser's reset value is not a real line sample, so rx_prev
    // only follows rx_s once both flops hold genuine samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_sync_vld <= 2'b00;
            r_rx_prev  <= 1'b0;
        end else begin
            r_sync1    <= rx_i;
            r_rx_s     <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_rx_prev  <= r_rx_s & r_sync_vld[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
`ifdef UART_MON_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
`ifdef UART_MON_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_fall) r_state <= START;
                end
                START: begin
                    if (r_baud_cnt == c_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= r_rx_s ? IDLE : DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`ifdef UART_MON_PARITY_EN
                PARITY: begin
                    if (w_bit_tick) begin
                        r_baud_cnt   <= '0;
                        r_par_bad    <= (^r_shift) != r_rx_s;
                        r_parity_err <= (^r_shift) != r_rx_s;
                        r_state      <= STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_tick) begin
                        r_baud_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (r_rx_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_overflow <= 1'b0;
        else       r_overflow <= w_push & w_full & ~w_pop;
    end

    uart_mon_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_monitor
// Brief    : Self-checking bench for uart_tx_monitor with a byte scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_monitor;
    localparam int CPB = 33;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] byte_o;
    logic       byte_valid_o, frame_err_o, overflow_o, busy_o;
`ifdef UART_MON_PARITY_EN
    logic       parity_err_o;
`endif

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_ovf = 0, n_perr = 0, n_pop = 0;
    int busy_run = 0, busy_max = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_tx_monitor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (ready),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
`ifdef UART_MON_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    // Observer and scoreboard: pops happen on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err_o) n_ferr++;
            if (overflow_o)  n_ovf++;
`ifdef UART_MON_PARITY_EN
            if (parity_err_o) n_perr++;
`endif
            if (busy_o) busy_run++; else busy_run = 0;
            if (busy_run > busy_max) busy_max = busy_run;
            if (byte_valid_o && ready) begin
                n_pop++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected got %h required no byte", byte_o);
                end else begin
                    exp_b = q.pop_front();
                    if (byte_o !== exp_b) begin
                        errors++;
                        $display("FAIL scoreboard_byte got %h required %h", byte_o, exp_b);
                    end
                end
            end
        end
    end

    task automatic line(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit expect_it, input logic pbit);
        if (expect_it) q.push_back(d);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef UART_MON_PARITY_EN
        line(pbit, CPB);
`endif
        line(1'b1, CPB);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (4) @(negedge clk);
        check_int("reset_valid", int'(byte_valid_o), 0);
        check_int("reset_busy",  int'(busy_o), 0);
        check_int("reset_byte",  int'(byte_o), 0);
        check_int("reset_ferr",  int'(frame_err_o), 0);
        check_int("reset_ovf",   int'(overflow_o), 0);
        rst = 1'b0;
        line(1'b1, 10);
    endtask

    task automatic test_back_to_back();
        int f0, o0, p0;
        f0 = n_ferr; o0 = n_ovf; p0 = n_pop;
        ready = 1'b1;
        send(8'h55, 1'b1, 1'b0);
        send(8'hA3, 1'b1, 1'b0);
        line(1'b1, 40);
        check_int("t1_pops",      n_pop - p0, 2);
        check_int("t1_queue",     q.size(), 0);
        check_int("t1_frame_err", n_ferr - f0, 0);
        check_int("t1_overflow",  n_ovf - o0, 0);
    endtask

    task automatic test_frame_error();
        int f0, p0;
        logic [7:0] d;
        f0 = n_ferr; p0 = n_pop; d = 8'h3C;
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef UART_MON_PARITY_EN
        line(1'b0, CPB);
`endif
        line(1'b0, 2 * CPB);
        line(1'b1, 2 * CPB);
        check_int("t2_frame_err_pulses", n_ferr - f0, 1);
        check_int("t2_fifo_empty", int'(byte_valid_o), 0);
        check_int("t2_no_pop", n_pop - p0, 0);
        send(8'h12, 1'b1, 1'b0);
        line(1'b1, 20);
        check_int("t2_next_pop", n_pop - p0, 1);
        check_int("t2_queue", q.size(), 0);
    endtask

    task automatic test_glitch();
        int f0, p0;
        f0 = n_ferr; p0 = n_pop;
        busy_max = 0;
        line(1'b0, 10);
        line(1'b1, 60);
        checks++;
        if (busy_max < 1 || busy_max > 18) begin
            errors++;
            $display("FAIL t3_busy_len got %0d required 1..18", busy_max);
        end
        check_int("t3_no_pop", n_pop - p0, 0);
        check_int("t3_no_ferr", n_ferr - f0, 0);
        check_int("t3_valid", int'(byte_valid_o), 0);
    endtask

    task automatic test_overflow();
        int o0, p0;
        o0 = n_ovf; p0 = n_pop;
        ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'(i), i < 8, 1'(^8'(i)));
        line(1'b1, 10);
        check_int("t4_overflow_pulses", n_ovf - o0, 1);
        check_int("t4_valid_held", int'(byte_valid_o), 1);
        check_int("t4_head", int'(byte_o), 0);
        ready = 1'b1;
        line(1'b1, 20);
        check_int("t4_drained", n_pop - p0, 8);
        check_int("t4_queue", q.size(), 0);
    endtask

    task automatic test_reset_mid_frame();
        int f0, p0;
        logic [7:0] d;
        f0 = n_ferr; p0 = n_pop; d = 8'hA3;
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(d[i], CPB);
        line(d[4], 16);
        rx = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_max = 0;
        line(1'b0, 100);
        check_int("t5_busy_low_line", busy_max, 0);
        check_int("t5_no_ferr", n_ferr - f0, 0);
        check_int("t5_valid", int'(byte_valid_o), 0);
        line(1'b1, 40);
        send(8'hA3, 1'b1, 1'b0);
        line(1'b1, 20);
        check_int("t5_next_pop", n_pop - p0, 1);
        check_int("t5_queue", q.size(), 0);
    endtask

`ifdef UART_MON_PARITY_EN
    task automatic test_parity();
        int e0, p0;
        e0 = n_perr; p0 = n_pop;
        send(8'h01, 1'b0, 1'b0);
        line(1'b1, 20);
        check_int("t6_parity_pulse", n_perr - e0, 1);
        check_int("t6_nothing_queued", n_pop - p0, 0);
        send(8'h01, 1'b1, 1'b1);
        line(1'b1, 20);
        check_int("t6_good_pop", n_pop - p0, 1);
        check_int("t6_no_new_err", n_perr - e0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_MON_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
